// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register bank: header layout, control-word
// bit positions, FSM state encodings and the 8N1 frame builder.
package uart_reg_pkg;

  localparam int RW_BIT         = 7;
  localparam int ADDR_MSB       = 6;
  localparam int CTRL_ADDR      = 0;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_START_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_TX_BYTE = 2'd2,
    ST_TX_GAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bit 0 is sent first: start bit, data LSB first, stop bit.
  function automatic logic [9:0] uart_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronises rx_in, validates the start bit at
// mid-bit, samples data LSB first and flags a low stop bit as a frame error.
module uart_rx_byte
  import uart_reg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       valid_out,
  output logic       frame_err_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  logic            rx_meta_r;
  logic            rx_sync_r;
  logic            rx_prev_r;
  rx_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]      bit_r;
  logic [7:0]      shift_r;

  // Receiver state machine; only a falling edge (not a held-low line) starts a frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta_r     <= 1'b1;
      rx_sync_r     <= 1'b1;
      rx_prev_r     <= 1'b1;
      state_r       <= RX_IDLE;
      cnt_r         <= '0;
      bit_r         <= 3'd0;
      shift_r       <= 8'h00;
      byte_out      <= 8'h00;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      rx_meta_r     <= rx_in;
      rx_sync_r     <= rx_meta_r;
      rx_prev_r     <= rx_sync_r;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r <= '0;
          if (rx_prev_r && !rx_sync_r) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == CNT_W'(HALF - 1)) begin
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_r   <= '0;
            shift_r <= {rx_sync_r, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (rx_sync_r) begin
              valid_out <= 1'b1;
              byte_out  <= shift_r;
            end else begin
              frame_err_out <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_bank_rw.sv
// UART-driven register bank: header byte selects read or write of one register;
// writes land atomically with a strobe, reads stream a header-time snapshot on tx_out.
module uart_reg_bank_rw
  import uart_reg_pkg::*;
#(
  parameter int  CLKS_PER_BIT = 142,
  parameter int  NUM_REGS     = 8,
  parameter int  REG_BYTES    = 2,
  parameter int  TIMEOUT_BITS = 20,
  localparam int REG_W        = 8 * REG_BYTES,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rx_in,
  output logic                      tx_out,
  input  logic                      code_phase_done_in,
  output logic [NUM_REGS*REG_W-1:0] regs_out,
  output logic                      wr_strobe_out,
  output logic [ADDR_W-1:0]         wr_addr_out,
  output logic                      busy_out,
  output logic [7:0]                err_cnt_out
);

  localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W    = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

  logic [7:0]        rx_byte_s;
  logic              rx_valid_s;
  logic              rx_ferr_s;
  state_t            state_r;
  logic [REG_W-1:0]  regs_r [NUM_REGS];
  logic [REG_W-1:0]  shadow_r;
  logic [REG_W-1:0]  snap_r;
  logic [REG_W-1:0]  next_shadow_s;
  logic [REG_W-1:0]  rd_val_s;
  logic [ADDR_MSB:0] addr_r;
  logic [BIDX_W-1:0] byte_idx_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [CNT_W-1:0]  tx_cnt_r;
  logic [3:0]        tx_bit_r;
  logic [9:0]        tx_frame_r;
  logic              tx_r;
  logic              strobe_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        err_cnt_r;
  logic              hdr_ok_s;
  logic              addr_ok_s;
  logic              timeout_s;
  logic              err_inc_s;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rx_in         (rx_in),
    .byte_out      (rx_byte_s),
    .valid_out     (rx_valid_s),
    .frame_err_out (rx_ferr_s)
  );

  assign next_shadow_s = REG_W'({shadow_r, rx_byte_s});
  assign hdr_ok_s      = ({1'b0, rx_byte_s[ADDR_MSB:0]} < 8'(NUM_REGS));
  assign addr_ok_s     = ({1'b0, addr_r} < 8'(NUM_REGS));
  assign timeout_s     = (gap_cnt_r == GAP_W'(GAP_LIMIT));

  // Read data for a header arriving this cycle; out-of-range reads return zero.
  always_comb begin
    rd_val_s = '0;
    if (hdr_ok_s) begin
      rd_val_s = regs_r[rx_byte_s[ADDR_W-1:0]];
    end else begin
      rd_val_s = '0;
    end
  end

  // Frame errors count in every state; timeouts only while collecting write data.
  always_comb begin
    err_inc_s = 1'b0;
    if (rx_ferr_s) begin
      err_inc_s = 1'b1;
    end else if (state_r == ST_WR_DATA && !rx_valid_s && timeout_s) begin
      err_inc_s = 1'b1;
    end else begin
      err_inc_s = 1'b0;
    end
  end

  // Command FSM, register file, TX shifter and error counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= ST_IDLE;
      for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= '0;
      shadow_r   <= '0;
      snap_r     <= '0;
      addr_r     <= '0;
      byte_idx_r <= '0;
      gap_cnt_r  <= '0;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      tx_frame_r <= 10'h3FF;
      tx_r       <= 1'b1;
      strobe_r   <= 1'b0;
      wr_addr_r  <= '0;
      err_cnt_r  <= 8'h00;
    end else begin
      strobe_r <= 1'b0;
      if (err_inc_s && err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
      // A write to reg0 later in this block overrides the clear.
      if (code_phase_done_in) begin
        regs_r[CTRL_ADDR][CTRL_START_BIT] <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (rx_valid_s) begin
            addr_r     <= rx_byte_s[ADDR_MSB:0];
            byte_idx_r <= '0;
            gap_cnt_r  <= '0;
            if (rx_byte_s[RW_BIT]) begin
              tx_frame_r <= uart_frame(rd_val_s[REG_W-1 -: 8]);
              snap_r     <= rd_val_s << 4'd8;
              tx_r       <= 1'b0;
              tx_cnt_r   <= '0;
              tx_bit_r   <= 4'd0;
              state_r    <= ST_TX_BYTE;
            end else begin
              state_r <= ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (rx_ferr_s) begin
            state_r <= ST_IDLE;
          end else if (rx_valid_s) begin
            shadow_r  <= next_shadow_s;
            gap_cnt_r <= '0;
            if (byte_idx_r == BIDX_W'(REG_BYTES - 1)) begin
              if (addr_ok_s) begin
                regs_r[addr_r[ADDR_W-1:0]] <= next_shadow_s;
                strobe_r                   <= 1'b1;
                wr_addr_r                  <= addr_r[ADDR_W-1:0];
              end
              state_r <= ST_IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + BIDX_W'(1);
            end
          end else if (timeout_s) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        ST_TX_BYTE: begin
          if (tx_cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == 4'd9) begin
              state_r <= ST_TX_GAP;
            end else begin
              tx_bit_r <= tx_bit_r + 4'd1;
              tx_r     <= tx_frame_r[tx_bit_r + 4'd1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
          end
        end
        ST_TX_GAP: begin
          if (tx_cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
            tx_cnt_r <= '0;
            if (byte_idx_r == BIDX_W'(REG_BYTES - 1)) begin
              state_r <= ST_IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + BIDX_W'(1);
              tx_frame_r <= uart_frame(snap_r[REG_W-1 -: 8]);
              snap_r     <= snap_r << 4'd8;
              tx_bit_r   <= 4'd0;
              tx_r       <= 1'b0;
              state_r    <= ST_TX_BYTE;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*REG_W +: REG_W] = regs_r[k];
  end

  assign tx_out        = tx_r;
  assign wr_strobe_out = strobe_r;
  assign wr_addr_out   = wr_addr_r;
  assign busy_out      = (state_r != ST_IDLE);
  assign err_cnt_out   = err_cnt_r;

endmodule

// File: tb/tb_uart_reg_bank_rw.sv
// Scoreboard bench for uart_reg_bank_rw: expected writes and TX bytes are queued
// as stimulus is sent and popped by strobe / TX-line monitors.
module tb_uart_reg_bank_rw;

  localparam int CPB = 16;
  localparam int NR  = 8;
  localparam int RB  = 2;
  localparam int RW  = 16;

  logic           clk = 1'b0;
  logic           rst_in = 1'b1;
  logic           rx_in = 1'b1;
  logic           code_phase_done_in = 1'b0;
  logic           tx_out;
  logic [NR*RW-1:0] regs_out;
  logic           wr_strobe_out;
  logic [2:0]     wr_addr_out;
  logic           busy_out;
  logic [7:0]     err_cnt_out;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;
  int exp_err = 0;
  logic [7:0]    exp_tx_q[$];
  logic [18:0]   exp_wr_q[$];
  int            tx_start_cyc[$];
  logic [RW-1:0] exp_regs [NR];

  uart_reg_bank_rw #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR), .REG_BYTES(RB), .TIMEOUT_BITS(20)) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .rx_in              (rx_in),
    .tx_out             (tx_out),
    .code_phase_done_in (code_phase_done_in),
    .regs_out           (regs_out),
    .wr_strobe_out      (wr_strobe_out),
    .wr_addr_out        (wr_addr_out),
    .busy_out           (busy_out),
    .err_cnt_out        (err_cnt_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin : wr_mon
    logic [18:0]   e;
    logic [RW-1:0] got;
    if (!rst_in && wr_strobe_out === 1'b1) begin
      strobe_cnt++;
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        $display("FAIL wr_unexpected: strobe with addr %0d, none expected", wr_addr_out);
      end else begin
        e = exp_wr_q.pop_front();
        got = regs_out[int'(wr_addr_out)*RW +: RW];
        if (wr_addr_out !== e[18:16]) $display("FAIL wr_addr: got %0d expected %0d", wr_addr_out, e[18:16]);
        else n_pass++;
        n_checks++;
        if (got !== e[15:0]) $display("FAIL wr_value: got %h expected %h", got, e[15:0]);
        else n_pass++;
      end
    end
  end

  // TX monitor: decodes 8N1 frames at mid-bit and compares with queued bytes.
  always begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       stopb;
    @(negedge clk);
    if (!rst_in && tx_out === 1'b0) begin
      tx_start_cyc.push_back(cyc);
      repeat (7) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_out;
      end
      repeat (CPB) @(negedge clk);
      stopb = tx_out;
      n_checks++;
      if (stopb !== 1'b1) $display("FAIL tx_stop: got %b expected 1", stopb);
      else n_pass++;
      n_checks++;
      if (exp_tx_q.size() == 0) begin
        $display("FAIL tx_unexpected: got byte %h, none expected", b);
      end else begin
        e = exp_tx_q.pop_front();
        if (b !== e) $display("FAIL tx_byte: got %h expected %h", b, e);
        else n_pass++;
      end
    end
  end

  function automatic logic [NR*RW-1:0] image();
    logic [NR*RW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*RW +: RW] = exp_regs[k];
    return v;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pulse_idx);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10*CPB; i++) begin
      @(negedge clk);
      rx_in = fr[i/CPB];
      code_phase_done_in = (i == pulse_idx);
    end
    @(negedge clk);
    rx_in = 1'b1;
    code_phase_done_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, -1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n*CPB) @(negedge clk);
  endtask

  task automatic push_write(input logic [2:0] a, input logic [RW-1:0] v);
    exp_wr_q.push_back({a, v});
    exp_regs[a] = v;
    exp_strobes++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_in = 1'b0;
    for (int k = 0; k < NR; k++) exp_regs[k] = '0;
    @(negedge clk);
    n_checks++; if (regs_out !== image()) $display("FAIL rst_regs: got %h expected 0", regs_out); else n_pass++;
    n_checks++; if (tx_out !== 1'b1) $display("FAIL rst_tx: got %b expected 1", tx_out); else n_pass++;
    n_checks++; if (wr_strobe_out !== 1'b0) $display("FAIL rst_strobe: got %b expected 0", wr_strobe_out); else n_pass++;
    n_checks++; if (wr_addr_out !== 3'd0) $display("FAIL rst_addr: got %0d expected 0", wr_addr_out); else n_pass++;
    n_checks++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_out); else n_pass++;
    n_checks++; if (err_cnt_out !== 8'd0) $display("FAIL rst_err: got %0d expected 0", err_cnt_out); else n_pass++;
  endtask

  task automatic test_write();
    push_write(3'd3, 16'hABCD);
    send_byte(8'h03); send_byte(8'hAB); send_byte(8'hCD);
    repeat (4) @(negedge clk);
    n_checks++; if (regs_out !== image()) $display("FAIL write_regs: got %h expected %h", regs_out, image()); else n_pass++;
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL write_pending: got %0d queued expected 0", exp_wr_q.size()); else n_pass++;
    idle_bits(2);
    n_checks++; if (wr_addr_out !== 3'd3) $display("FAIL write_addr_hold: got %0d expected 3", wr_addr_out); else n_pass++;
    n_checks++; if (strobe_cnt != 1) $display("FAIL write_strobes: got %0d expected 1", strobe_cnt); else n_pass++;
  endtask

  task automatic test_readback();
    int hdr_cyc;
    tx_start_cyc.delete();
    exp_tx_q.push_back(8'hAB);
    exp_tx_q.push_back(8'hCD);
    hdr_cyc = cyc;
    send_byte(8'h83);
    for (int i = 0; i < 800 && busy_out === 1'b1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_checks++; if (busy_out !== 1'b0) $display("FAIL rd_busy: got %b expected 0", busy_out); else n_pass++;
    n_checks++; if (exp_tx_q.size() != 0) $display("FAIL rd_pending: got %0d bytes left expected 0", exp_tx_q.size()); else n_pass++;
    n_checks++;
    if (tx_start_cyc.size() != 2) begin
      $display("FAIL rd_frames: got %0d frames expected 2", tx_start_cyc.size());
    end else if (tx_start_cyc[1] - tx_start_cyc[0] != 11*CPB) begin
      $display("FAIL rd_spacing: got %0d clks expected %0d", tx_start_cyc[1] - tx_start_cyc[0], 11*CPB);
    end else n_pass++;
    n_checks++;
    if (tx_start_cyc.size() == 0 || tx_start_cyc[0] - hdr_cyc < 9*CPB || tx_start_cyc[0] - hdr_cyc > 10*CPB + 4)
      $display("FAIL rd_latency: got first start %0d clks after header start, expected within its stop bit", (tx_start_cyc.size() == 0) ? -1 : tx_start_cyc[0] - hdr_cyc);
    else n_pass++;
  endtask

  task automatic test_start_clear();
    push_write(3'd0, 16'h0003);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    repeat (2) @(negedge clk);
    n_checks++; if (regs_out[15:0] !== 16'h0003) $display("FAIL clr_wr: got %h expected 0003", regs_out[15:0]); else n_pass++;
    code_phase_done_in = 1'b1;
    @(negedge clk);
    code_phase_done_in = 1'b0;
    exp_regs[0] = 16'h0001;
    n_checks++; if (regs_out !== image()) $display("FAIL clr_next_cycle: got %h expected %h", regs_out, image()); else n_pass++;
    push_write(3'd0, 16'h0003);
    send_byte(8'h00); send_byte(8'h00); send_frame(8'h03, 1'b1, 10*CPB - 5);
    repeat (2) @(negedge clk);
    n_checks++; if (regs_out !== image()) $display("FAIL clr_write_wins: got %h expected %h", regs_out, image()); else n_pass++;
  endtask

  task automatic test_timeout();
    send_byte(8'h02); send_byte(8'h11);
    idle_bits(21);
    send_byte(8'h22);
    exp_err++;
    n_checks++; if (err_cnt_out !== 8'(exp_err)) $display("FAIL to_err: got %0d expected %0d", err_cnt_out, exp_err); else n_pass++;
    n_checks++; if (regs_out !== image()) $display("FAIL to_regs: got %h expected %h", regs_out, image()); else n_pass++;
    n_checks++; if (strobe_cnt != exp_strobes) $display("FAIL to_strobe: got %0d expected %0d", strobe_cnt, exp_strobes); else n_pass++;
    // 0x22 opened a new (out-of-range) write frame that now also times out.
    idle_bits(24);
    exp_err++;
    n_checks++; if (err_cnt_out !== 8'(exp_err)) $display("FAIL to_err2: got %0d expected %0d", err_cnt_out, exp_err); else n_pass++;
    n_checks++; if (busy_out !== 1'b0) $display("FAIL to_busy: got %b expected 0", busy_out); else n_pass++;
  endtask

  task automatic test_frame_err_bad_addr();
    send_frame(8'h55, 1'b0, -1);
    idle_bits(2);
    exp_err++;
    n_checks++; if (err_cnt_out !== 8'(exp_err)) $display("FAIL ferr_cnt: got %0d expected %0d", err_cnt_out, exp_err); else n_pass++;
    send_byte(8'h0A); send_byte(8'h12); send_byte(8'h34);
    idle_bits(2);
    n_checks++; if (regs_out !== image()) $display("FAIL badwr_regs: got %h expected %h", regs_out, image()); else n_pass++;
    n_checks++; if (strobe_cnt != exp_strobes) $display("FAIL badwr_strobe: got %0d expected %0d", strobe_cnt, exp_strobes); else n_pass++;
    exp_tx_q.push_back(8'h00);
    exp_tx_q.push_back(8'h00);
    send_byte(8'h8A);
    for (int i = 0; i < 800 && busy_out === 1'b1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_checks++; if (busy_out !== 1'b0) $display("FAIL badrd_busy: got %b expected 0", busy_out); else n_pass++;
    n_checks++; if (exp_tx_q.size() != 0) $display("FAIL badrd_pending: got %0d bytes left expected 0", exp_tx_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] fr;
    push_write(3'd6, 16'hBEEF);
    send_byte(8'h06); send_byte(8'hBE); send_byte(8'hEF);
    idle_bits(1);
    n_checks++; if (regs_out !== image()) $display("FAIL pre_rst_regs: got %h expected %h", regs_out, image()); else n_pass++;
    send_byte(8'h04); send_byte(8'h12);
    fr = {1'b1, 8'h34, 1'b0};
    for (int i = 0; i < 5*CPB; i++) begin
      @(negedge clk);
      rx_in = fr[i/CPB];
    end
    @(negedge clk);
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    for (int k = 0; k < NR; k++) exp_regs[k] = '0;
    exp_err = 0;
    @(negedge clk);
    n_checks++; if (regs_out !== image()) $display("FAIL mrst_regs: got %h expected 0", regs_out); else n_pass++;
    n_checks++; if (tx_out !== 1'b1) $display("FAIL mrst_tx: got %b expected 1", tx_out); else n_pass++;
    n_checks++; if (wr_strobe_out !== 1'b0) $display("FAIL mrst_strobe: got %b expected 0", wr_strobe_out); else n_pass++;
    n_checks++; if (wr_addr_out !== 3'd0) $display("FAIL mrst_addr: got %0d expected 0", wr_addr_out); else n_pass++;
    n_checks++; if (busy_out !== 1'b0) $display("FAIL mrst_busy: got %b expected 0", busy_out); else n_pass++;
    n_checks++; if (err_cnt_out !== 8'd0) $display("FAIL mrst_err: got %0d expected 0", err_cnt_out); else n_pass++;
    push_write(3'd1, 16'h0005);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    idle_bits(1);
    n_checks++; if (regs_out !== image()) $display("FAIL post_rst_regs: got %h expected %h", regs_out, image()); else n_pass++;
    n_checks++; if (wr_addr_out !== 3'd1) $display("FAIL post_rst_addr: got %0d expected 1", wr_addr_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_start_clear();
    test_timeout();
    test_frame_err_bad_addr();
    test_reset_mid_frame();
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL end_wr_pending: got %0d expected 0", exp_wr_q.size()); else n_pass++;
    n_checks++; if (strobe_cnt != exp_strobes) $display("FAIL end_strobes: got %0d expected %0d", strobe_cnt, exp_strobes); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
